// File: rtl/pipeline_trace_capture_pkg.sv
// pipeline_trace_pkg
// Shared encodings for the pipeline trace capture block: the capture state
// machine states, the stop modes, and a helper that folds the raw two-bit
// mode input onto a legal stop mode.
package pipeline_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RING = 2'd0,
    TRIG = 2'd1,
    FILL = 2'd2
  } mode_t;

  // The unused encoding 3 behaves exactly like FILL.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'd0:    m = RING;
      2'd1:    m = TRIG;
      default: m = FILL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pipeline_trace_capture_if.sv
// pipeline_trace_capture_if
// Read-back port of the trace capture block.
//   RdReq   : read request, one result per requesting cycle
//   RdAddr  : logical sample index, 0 = oldest stored sample
//   RdChan  : probe channel select
//   RdData  : returned sample, valid one cycle after RdReq
//   RdValid : high exactly the cycle after RdReq
// The debug unit (or bench) uses the master modport; the capture block uses
// the slave modport.
interface pipeline_trace_capture_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 4,
  parameter int CW         = 2
);
  logic                  RdReq;
  logic [AW-1:0]         RdAddr;
  logic [CW-1:0]         RdChan;
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdValid;

  modport master (
    output RdReq, RdAddr, RdChan,
    input  RdData, RdValid
  );

  modport slave (
    input  RdReq, RdAddr, RdChan,
    output RdData, RdValid
  );
endinterface

// File: rtl/pipeline_trace_capture_trace_ram.sv
// trace_ram
// Simple dual-port sample store: one write port carrying all channels of a
// sample side by side, one synchronous read port. When the read and write
// hit the same address in the same cycle the read returns the new data.
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : full sample (all channels)
//   re    : read enable; rdata updates only when high
//   raddr : read address
//   rdata : registered read data
module trace_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write-first: a colliding read forwards the incoming word instead of the
  // stale array content.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/pipeline_trace_capture.sv
// pipeline_trace_capture
// Passive trace recorder that sits beside the MIPS core. Each qualified cycle
// while capturing, all NUM_CH probe buses are stored into a DEPTH-entry ring.
// Capture stops on Stop (RING), when the ring is full (FILL) or PostCount
// samples after a trigger (TRIG). Samples are read back by logical index.
//   ClockIn   : clock, rising edge
//   Reset     : synchronous, active-high
//   Enable    : sample qualifier
//   ProbeData : channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   TriggerIn : trigger event, honoured only while ARMED in TRIG mode
//   Mode      : stop mode, latched at Arm
//   Arm       : restart capture (clears pointers, enters ARMED)
//   Stop      : end capture from ARMED/POST
//   PostCount : samples stored after the trigger sample, latched at Arm
//   rd        : read-back port (slave side)
//   State     : IDLE/ARMED/POST/DONE
//   Count     : stored samples, saturating at DEPTH
//   Wrapped   : at least one sample has been overwritten
module pipeline_trace_capture
  import pipeline_trace_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_CH     = 4,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         ClockIn,
  input  logic                         Reset,
  input  logic                         Enable,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ProbeData,
  input  logic                         TriggerIn,
  input  logic [1:0]                   Mode,
  input  logic                         Arm,
  input  logic                         Stop,
  input  logic [AW-1:0]                PostCount,
  pipeline_trace_capture_if.slave      rd,
  output logic [1:0]                   State,
  output logic [AW:0]                  Count,
  output logic                         Wrapped
);

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_t      state_q, state_d;
  mode_t       mode_q;
  logic [AW-1:0] post_cfg_q;
  logic [AW-1:0] post_q, post_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q, count_d, count_vis;
  logic          wrapped_q;
  logic          capturing, write_en;

  logic [AW-1:0]                rd_phys;
  logic                         rd_in_range;
  logic                         rd_valid_q;
  logic                         rd_in_range_q;
  logic [CW-1:0]                rd_chan_q;
  logic [NUM_CH*DATA_WIDTH-1:0] ram_dout;
  logic [DATA_WIDTH-1:0]        rd_word;

  assign capturing = (state_q == ARMED) || (state_q == POST);

  // An Arm or Reset cycle discards the sample so the restarted capture
  // begins cleanly at slot 0.
  assign write_en = capturing && Enable && !Arm && !Reset;

  // State register for the capture FSM and the post-trigger countdown.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q <= IDLE;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
    end
  end

  // Next-state logic. Arm overrides everything else; inside ARMED/POST a
  // Stop beats any mode-specific transition in the same cycle.
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    if (Arm) begin
      state_d = ARMED;
      post_d  = '0;
    end else begin
      case (state_q)
        ARMED: begin
          case (mode_q)
            FILL: begin
              if (write_en && (count_q == DEPTH_C - (AW+1)'(1))) begin
                state_d = DONE;
              end
            end
            TRIG: begin
              if (TriggerIn) begin
                if (post_cfg_q == '0) begin
                  state_d = DONE;
                end else begin
                  state_d = POST;
                  post_d  = post_cfg_q;
                end
              end
            end
            default: begin
            end
          endcase
          if (Stop) begin
            state_d = DONE;
          end
        end
        POST: begin
          if (write_en) begin
            post_d = post_q - AW'(1);
            if (post_q == AW'(1)) begin
              state_d = DONE;
            end
          end
          if (Stop) begin
            state_d = DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Occupancy after this cycle's write; also used to judge reads that land
  // on the slot being written right now.
  always_comb begin
    count_d = count_q;
    if (write_en && (count_q != DEPTH_C)) begin
      count_d = count_q + (AW+1)'(1);
    end
    count_vis = Arm ? '0 : count_d;
  end

  // Write pointer, occupancy and configuration latched at Arm. FILL stops
  // on the wrapping write, so it never reports Wrapped.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      mode_q     <= RING;
      post_cfg_q <= '0;
    end else if (Arm) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      mode_q     <= decode_mode(Mode);
      post_cfg_q <= PostCount;
    end else if (write_en) begin
      wr_ptr_q <= wr_ptr_q + AW'(1);
      count_q  <= count_d;
      if ((wr_ptr_q == LAST_PTR) && (mode_q != FILL)) begin
        wrapped_q <= 1'b1;
      end
    end
  end

  // Once wrapped, the oldest sample sits at the write pointer.
  assign rd_phys     = (wrapped_q ? wr_ptr_q : '0) + rd.RdAddr;
  assign rd_in_range = ({1'b0, rd.RdAddr} < count_vis);

  trace_ram #(
    .WIDTH (NUM_CH*DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (ClockIn),
    .we    (write_en),
    .waddr (wr_ptr_q),
    .wdata (ProbeData),
    .re    (rd.RdReq),
    .raddr (rd_phys),
    .rdata (ram_dout)
  );

  // Read-side control travels one cycle alongside the RAM access.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      rd_valid_q    <= 1'b0;
      rd_in_range_q <= 1'b0;
      rd_chan_q     <= '0;
    end else begin
      rd_valid_q <= rd.RdReq;
      if (rd.RdReq) begin
        rd_in_range_q <= rd_in_range;
        rd_chan_q     <= rd.RdChan;
      end
    end
  end

  // Channel select after the RAM; out-of-range reads (and the cycles after
  // reset, before any read) return zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_chan_q == CW'(k)) begin
        rd_word = ram_dout[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    rd.RdData = rd_in_range_q ? rd_word : '0;
  end

  assign rd.RdValid = rd_valid_q;
  assign State      = state_q;
  assign Count      = count_q;
  assign Wrapped    = wrapped_q;

endmodule

// File: tb/tb_pipeline_trace_capture.sv
// tb_pipeline_trace_capture
// Directed bench: DEPTH=16, NUM_CH=2, DATA_WIDTH=32. Sample n carries n on
// channel 0 and ~n on channel 1, so every expected read value is known.
module tb_pipeline_trace_capture;

  localparam int DW  = 32;
  localparam int NCH = 2;
  localparam int DEP = 16;
  localparam int AW  = 4;
  localparam int CW  = 1;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [NCH*DW-1:0] probe_data;
  logic              trigger_in;
  logic [1:0]        mode;
  logic              arm;
  logic              stop;
  logic [AW-1:0]     post_count;
  logic [1:0]        state;
  logic [AW:0]       count;
  logic              wrapped;

  int num_checks;
  int num_fails;

  pipeline_trace_capture_if #(.DATA_WIDTH(DW), .AW(AW), .CW(CW)) rd_bus ();

  pipeline_trace_capture #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .DEPTH      (DEP)
  ) dut (
    .ClockIn   (clk),
    .Reset     (reset),
    .Enable    (enable),
    .ProbeData (probe_data),
    .TriggerIn (trigger_in),
    .Mode      (mode),
    .Arm       (arm),
    .Stop      (stop),
    .PostCount (post_count),
    .rd        (rd_bus),
    .State     (state),
    .Count     (count),
    .Wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One capture cycle carrying sample n.
  task automatic applyStimulus(input logic en, input int n, input logic trig);
    logic [31:0] nv;
    nv         = n;
    enable     = en;
    probe_data = {~nv, nv};
    trigger_in = trig;
    tick();
    enable     = 1'b0;
    trigger_in = 1'b0;
  endtask

  task automatic armCapture(input logic [1:0] m, input logic [AW-1:0] pc);
    mode       = m;
    post_count = pc;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  task automatic doRead(input int addr, input int chan, input logic [31:0] expected,
                        input string tag);
    rd_bus.RdReq  = 1'b1;
    rd_bus.RdAddr = AW'(addr);
    rd_bus.RdChan = CW'(chan);
    tick();
    rd_bus.RdReq  = 1'b0;
    checkOutput({tag, "_valid"}, 64'(rd_bus.RdValid), 64'd1);
    checkOutput({tag, "_data"}, 64'(rd_bus.RdData), 64'(expected));
  endtask

  initial begin
    num_checks    = 0;
    num_fails     = 0;
    reset         = 1'b1;
    enable        = 1'b0;
    probe_data    = '0;
    trigger_in    = 1'b0;
    mode          = 2'd0;
    arm           = 1'b0;
    stop          = 1'b0;
    post_count    = '0;
    rd_bus.RdReq  = 1'b0;
    rd_bus.RdAddr = '0;
    rd_bus.RdChan = '0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_state", 64'(state), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_wrapped", 64'(wrapped), 64'd0);
    checkOutput("rst_rdvalid", 64'(rd_bus.RdValid), 64'd0);
    checkOutput("rst_rddata", 64'(rd_bus.RdData), 64'd0);

    // Enable ignored while IDLE
    applyStimulus(1'b1, 77, 1'b0);
    checkOutput("idle_count", 64'(count), 64'd0);

    // FILL
    armCapture(2'd2, '0);
    checkOutput("fill_armed", 64'(state), 64'd1);
    for (int n = 0; n < 15; n++) applyStimulus(1'b1, n, 1'b0);
    checkOutput("fill_pre_state", 64'(state), 64'd1);
    applyStimulus(1'b1, 15, 1'b0);
    checkOutput("fill_done_state", 64'(state), 64'd3);
    checkOutput("fill_done_count", 64'(count), 64'd16);
    for (int n = 16; n < 20; n++) applyStimulus(1'b1, n, 1'b0);
    checkOutput("fill_hold_count", 64'(count), 64'd16);
    checkOutput("fill_wrapped", 64'(wrapped), 64'd0);
    for (int a = 0; a < 16; a++) doRead(a, 0, 32'(a), $sformatf("fill_rd%0d", a));
    tick();
    checkOutput("fill_rdvalid_drop", 64'(rd_bus.RdValid), 64'd0);

    // RING
    armCapture(2'd0, '0);
    for (int n = 0; n <= 20; n++) applyStimulus(1'b1, n, 1'b0);
    checkOutput("ring_running", 64'(state), 64'd1);
    stop = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);
    stop = 1'b0;
    checkOutput("ring_state", 64'(state), 64'd3);
    checkOutput("ring_count", 64'(count), 64'd16);
    checkOutput("ring_wrapped", 64'(wrapped), 64'd1);
    doRead(0, 0, 32'd5, "ring_a0");
    doRead(15, 0, 32'd20, "ring_a15");
    doRead(3, 1, ~32'd8, "ring_a3c1");

    // TRIG, PostCount=3
    armCapture(2'd1, 4'd3);
    for (int n = 0; n < 9; n++) applyStimulus(1'b1, n, 1'b0);
    applyStimulus(1'b1, 9, 1'b1);
    checkOutput("trig_post", 64'(state), 64'd2);
    applyStimulus(1'b0, 99, 1'b0);
    applyStimulus(1'b1, 10, 1'b0);
    applyStimulus(1'b0, 99, 1'b1);
    applyStimulus(1'b1, 11, 1'b0);
    checkOutput("trig_post_hold", 64'(state), 64'd2);
    applyStimulus(1'b0, 99, 1'b0);
    applyStimulus(1'b1, 12, 1'b0);
    checkOutput("trig_done", 64'(state), 64'd3);
    checkOutput("trig_count", 64'(count), 64'd13);
    applyStimulus(1'b1, 13, 1'b1);
    checkOutput("trig_late_state", 64'(state), 64'd3);
    checkOutput("trig_late_count", 64'(count), 64'd13);
    doRead(12, 0, 32'd12, "trig_a12");
    doRead(10, 1, ~32'd10, "trig_a10c1");
    doRead(13, 0, 32'd0, "trig_a13_oob");

    // TRIG, PostCount=0, trigger with Enable low
    armCapture(2'd1, '0);
    for (int n = 0; n < 4; n++) applyStimulus(1'b1, n, 1'b0);
    applyStimulus(1'b0, 4, 1'b1);
    checkOutput("trig0_state", 64'(state), 64'd3);
    checkOutput("trig0_count", 64'(count), 64'd4);
    doRead(4, 0, 32'd0, "trig0_a4");

    // TRIG, PostCount=0, trigger with Enable high
    armCapture(2'd1, '0);
    for (int n = 0; n < 4; n++) applyStimulus(1'b1, n, 1'b0);
    applyStimulus(1'b1, 4, 1'b1);
    checkOutput("trig0e_state", 64'(state), 64'd3);
    checkOutput("trig0e_count", 64'(count), 64'd5);
    doRead(4, 0, 32'd4, "trig0e_a4");

    // Arm mid-POST, sample presented on the Arm cycle is dropped
    armCapture(2'd1, 4'd5);
    for (int n = 0; n < 3; n++) applyStimulus(1'b1, n, 1'b0);
    applyStimulus(1'b1, 3, 1'b1);
    checkOutput("rearm_post", 64'(state), 64'd2);
    enable = 1'b1;
    armCapture(2'd0, '0);
    enable = 1'b0;
    checkOutput("rearm_state", 64'(state), 64'd1);
    checkOutput("rearm_count", 64'(count), 64'd0);
    for (int n = 0; n < 7; n++) applyStimulus(1'b1, n, 1'b0);
    checkOutput("pre_reset_count", 64'(count), 64'd7);

    // Reset mid-ARMED with a read in flight
    reset         = 1'b1;
    rd_bus.RdReq  = 1'b1;
    rd_bus.RdAddr = 4'd2;
    rd_bus.RdChan = 1'b0;
    applyStimulus(1'b1, 7, 1'b0);
    reset        = 1'b0;
    rd_bus.RdReq = 1'b0;
    checkOutput("mid_rst_state", 64'(state), 64'd0);
    checkOutput("mid_rst_count", 64'(count), 64'd0);
    checkOutput("mid_rst_wrapped", 64'(wrapped), 64'd0);
    checkOutput("mid_rst_rdvalid", 64'(rd_bus.RdValid), 64'd0);
    checkOutput("mid_rst_rddata", 64'(rd_bus.RdData), 64'd0);

    // Arm and Stop together from ARMED: Arm wins
    armCapture(2'd0, '0);
    for (int n = 0; n < 3; n++) applyStimulus(1'b1, n, 1'b0);
    stop = 1'b1;
    armCapture(2'd0, '0);
    stop = 1'b0;
    checkOutput("armstop_state", 64'(state), 64'd1);
    checkOutput("armstop_count", 64'(count), 64'd0);

    // Read colliding with the write in the same cycle
    for (int n = 0; n < 3; n++) applyStimulus(1'b1, n, 1'b0);
    rd_bus.RdReq  = 1'b1;
    rd_bus.RdAddr = 4'd3;
    rd_bus.RdChan = 1'b0;
    applyStimulus(1'b1, 3, 1'b0);
    rd_bus.RdReq = 1'b0;
    checkOutput("wf_valid", 64'(rd_bus.RdValid), 64'd1);
    checkOutput("wf_data", 64'(rd_bus.RdData), 64'd3);
    checkOutput("wf_count", 64'(count), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
